seq_detect_scheduler: RTL and testbench
=======================================

Name: seq_detect_scheduler

Overview:
Time-shares one 01[0*]1 sequence detector among NUM_REQ requesters using round-robin arbitration. Each requester submits a WORD_W-bit word over a valid/ready handshake. The block clears the detector, shifts the word in MSB-first (one bit per cycle), counts detector hits, and returns a tagged result over a second valid/ready handshake. It sits between the requesters and the detector; it drives the detector's reset, enable and test-signal inputs and samples its z output.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
WORD_W, 8, bits per submitted word (2..32)
ID_W, $clog2(NUM_REQ), width of requester index (derived, not overridden)
CNT_W, $clog2(WORD_W+1), width of per-word hit count (derived)

Ports:
clk  in  1  main clock; all registers on posedge
rst  in  1  reset, asynchronous, active-high; all state cleared immediately on assertion
req_valid  in  NUM_REQ  per-requester word valid
req_word  in  NUM_REQ*WORD_W  packed words; requester i at [i*WORD_W +: WORD_W]
req_ready  out  NUM_REQ  one-hot accept; at most one bit high
det_rst  out  1  synchronous clear pulse to the detector
det_ena  out  1  detector enable
det_sig  out  1  serial bit to the detector
det_z  in  1  detector Mealy output, sampled in the same cycle as det_sig
res_valid  out  1  result available
res_id  out  ID_W  requester index of the result
res_count  out  CNT_W  detections in the word
res_ready  in  1  result consumer accept
busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, CLEAR, SHIFT, REPORT. Encoding is a packaged enum.
- Reset values: state=IDLE; req_ready=0; det_rst=0, det_ena=0, det_sig=0; res_valid=0, res_id=0, res_count=0; busy=0. Round-robin pointer resets to last_grant=NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - Grant goes to the first requester with req_valid, searching from last_grant+1 upward with wrap.
  - req_ready[g] is asserted combinationally only in IDLE, for that requester only.
  - On req_valid[g]&req_ready[g]: latch word and ID, update last_grant=g, go to CLEAR.
  - No valid requests: stay in IDLE, all outputs low.
- CLEAR: assert det_rst=1 for exactly one cycle; bit_idx=WORD_W-1; count=0; go to SHIFT.
- SHIFT:
  - Outputs: det_ena=1; det_sig=word[bit_idx].
  - If det_z=1 in that cycle, count increments. count saturates at 2^CNT_W-1; the saturation logic must still exist.
  - bit_idx decrements each cycle; at bit_idx==0 go to REPORT.
  - Duration is exactly WORD_W cycles.
- REPORT:
  - Outputs: res_valid=1; res_id and res_count are stable; det_ena=0.
  - Hold until res_ready=1, then go to IDLE on the next cycle.
  - res_ready is ignored in all other states.
- Latency: acceptance edge at T. CLEAR in cycle T+1. SHIFT in cycles T+2..T+1+WORD_W. res_valid first high at cycle T+2+WORD_W.
- Throughput: one word per WORD_W+3 cycles minimum. A new grant is possible in the IDLE cycle after the result handshake.
- Fairness:
  - A requester that is still valid after being served has the lowest priority next round.
  - No requester waits more than NUM_REQ-1 words.
- Requester behaviour:
  - A requester may drop req_valid while not granted; this is legal and has no effect.
  - req_word is sampled only at acceptance.
- Reset mid-operation: abort immediately to IDLE with all reset values. In-flight words are lost and no result is produced. det_rst is not pulsed; the next CLEAR reclears the detector.

Optional Feature:
Macro: SEQ_DETECT_SCHEDULER_STATS_EN.
- Defined:
  - Adds output total_hits [15:0]: the running sum of all det_z hits seen in SHIFT since reset. Saturates at 16'hFFFF. Reset value 0.
  - Adds output words_done [15:0]: incremented on each result handshake, wrapping modulo 2^16. Reset value 0.
- Undefined: both ports and their registers are absent. All other behaviour is identical.

Decomposition:
- Package seq_detect_pkg holds: state enum sched_state_t {IDLE, CLEAR, SHIFT, REPORT}; 7-segment digit constants shared with the display logic; stats width constant STATS_W=16.
- Sub-module rr_arbiter holds the round-robin pointer and one-hot grant, parameterised by NUM_REQ. Interface: req vector and advance strobe in; one-hot grant and index out. The scheduler FSM and shift/count datapath stay in the top module.

Test Plan:
- NUM_REQ=2, WORD_W=8; req0 sends 8'b0100_1000 (serial 0,1,0,0,1,0,0,0) -> det_rst pulse at T+1; 8 det_ena cycles; res_valid at T+10 with res_id=0, res_count=1.
- Word 8'hFF, then word 8'h00 -> each returns res_count=0; det_z is never asserted.
- req0 and req1 continuously valid, 4 words -> grant order 0,1,0,1; req_ready never two-hot.
- res_ready held low 5 cycles in REPORT -> res_valid, res_id and res_count held stable; no new req_ready until after the handshake.
- rst asserted at SHIFT cycle 4 -> outputs return to reset values asynchronously; after release, req1 alone valid is granted with last_grant=1; no stale result appears.
- With SEQ_DETECT_SCHEDULER_STATS_EN: three words of 8'b0100_1000 -> total_hits=3, words_done=3; after reset both read 0.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared state encoding and constants for the sequence-detector scheduler
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SHIFT  = 2'd2,
    REPORT = 2'd3
  } sched_state_t;

  localparam int STATS_W = 16;

  // Active-high segments, bit order gfedcba, digit 9 first.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg7_digit(input logic [3:0] d);
    seg7_digit = (d < 4'd10) ? SEG_DIGITS[d] : 7'h00;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot grant, pointer advanced on acceptance
module rr_arbiter import seq_detect_pkg::*; #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o
);

  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] sel;
  logic            found;
  int              idx;

  // Search starts just after the last winner, so a served requester drops to lowest priority.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    sel         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = ID_W'(idx);
      if (!found && req_i[sel]) begin
        found        = 1'b1;
        grant_o[sel] = 1'b1;
        grant_idx_o  = sel;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance_i) last_d = grant_idx_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= ID_W'(NUM_REQ - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// rtl/seq_detect_scheduler.sv - time-shares one 01[0*]1 detector among requesters, round-robin
// Optional statistics outputs enabled by SEQ_DETECT_SCHEDULER_STATS_EN.
module seq_detect_scheduler import seq_detect_pkg::*; #(
  parameter  int NUM_REQ = 2,
  parameter  int WORD_W  = 8,
  localparam int ID_W    = $clog2(NUM_REQ),
  localparam int CNT_W   = $clog2(WORD_W + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_word,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      det_rst,
  output logic                      det_ena,
  output logic                      det_sig,
  input  logic                      det_z,
  output logic                      res_valid,
  output logic [ID_W-1:0]           res_id,
  output logic [CNT_W-1:0]          res_count,
  input  logic                      res_ready,
  output logic                      busy
`ifdef SEQ_DETECT_SCHEDULER_STATS_EN
  ,
  output logic [STATS_W-1:0]        total_hits,
  output logic [STATS_W-1:0]        words_done
`endif
);

  localparam int              IDX_W   = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sched_state_t       state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               accept;

  assign accept = (state_q == IDLE) && |(req_valid & grant);
  assign busy   = (state_q != IDLE);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_valid),
    .advance_i   (accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    id_d      = id_q;
    bit_idx_d = bit_idx_q;
    count_d   = count_q;
    req_ready = '0;
    det_rst   = 1'b0;
    det_ena   = 1'b0;
    det_sig   = 1'b0;
    res_valid = 1'b0;
    res_id    = '0;
    res_count = '0;
    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (accept) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) word_d = req_word[i*WORD_W +: WORD_W];
          end
          id_d    = grant_idx;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        det_rst   = 1'b1;
        bit_idx_d = IDX_W'(WORD_W - 1);
        count_d   = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        det_ena = 1'b1;
        det_sig = word_q[bit_idx_q];
        if (det_z && (count_q != CNT_MAX)) count_d = count_q + 1'b1;
        bit_idx_d = bit_idx_q - 1'b1;
        if (bit_idx_q == '0) state_d = REPORT;
      end
      REPORT: begin
        res_valid = 1'b1;
        res_id    = id_q;
        res_count = count_q;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      word_q    <= '0;
      id_q      <= '0;
      bit_idx_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      id_q      <= id_d;
      bit_idx_q <= bit_idx_d;
      count_q   <= count_d;
    end
  end

`ifdef SEQ_DETECT_SCHEDULER_STATS_EN
  logic [STATS_W-1:0] total_hits_q, words_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_hits_q <= '0;
      words_done_q <= '0;
    end else begin
      if ((state_q == SHIFT) && det_z && (total_hits_q != '1)) total_hits_q <= total_hits_q + 1'b1;
      if ((state_q == REPORT) && res_ready) words_done_q <= words_done_q + 1'b1;
    end
  end

  assign total_hits = total_hits_q;
  assign words_done = words_done_q;
`endif

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// tb/tb_seq_detect_scheduler.sv - randomized self-checking bench for seq_detect_scheduler
module tb_seq_detect_scheduler;

  localparam int NUM_REQ = 2;
  localparam int WORD_W  = 8;
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CNT_W   = $clog2(WORD_W + 1);

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*WORD_W-1:0] req_word;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      det_rst, det_ena, det_sig, det_z;
  logic                      res_valid;
  logic [ID_W-1:0]           res_id;
  logic [CNT_W-1:0]          res_count;
  logic                      res_ready;
  logic                      busy;
`ifdef SEQ_DETECT_SCHEDULER_STATS_EN
  logic [15:0]               total_hits, words_done;
`endif

  seq_detect_scheduler #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_word  (req_word),
    .req_ready (req_ready),
    .det_rst   (det_rst),
    .det_ena   (det_ena),
    .det_sig   (det_sig),
    .det_z     (det_z),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_count (res_count),
    .res_ready (res_ready),
    .busy      (busy)
`ifdef SEQ_DETECT_SCHEDULER_STATS_EN
    ,
    .total_hits(total_hits),
    .words_done(words_done)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // External 01[0*]1 Mealy detector the scheduler drives.
  logic [1:0] dstate;
  assign det_z = det_ena && det_sig && (dstate == 2'd2);
  always @(posedge clk) begin
    if (rst || det_rst) dstate <= 2'd0;
    else if (det_ena) begin
      case (dstate)
        2'd0:    if (!det_sig) dstate <= 2'd1;
        2'd1:    if (det_sig)  dstate <= 2'd2;
        default: if (det_sig)  dstate <= 2'd0;
      endcase
    end
  end

  // Expected hits: repeatedly locate a 0, the 1 following it, and the next 1 (only zeros between).
  function automatic int ref_hits(input logic [WORD_W-1:0] w);
    int i = WORD_W - 1;
    int hits = 0;
    while (i >= 0) begin
      while (i >= 0 && w[i])  i--;
      while (i >= 0 && !w[i]) i--;
      i--;
      while (i >= 0 && !w[i]) i--;
      if (i >= 0) begin
        hits++;
        i--;
      end
    end
    return hits;
  endfunction

  function automatic int exp_grant(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  typedef struct { int id; int cnt; int acc; } item_t;
  item_t q[$];
  int    cyc = 0, model_last = NUM_REQ - 1, ena_cnt = 0, clr_due = -1;
  bit    res_seen = 0, hold = 0;
  int    hold_id, hold_cnt;

  always @(negedge clk) begin
    int g;
    logic [WORD_W-1:0] w;
    cyc++;
    if (rst) begin
      q.delete();
      model_last = NUM_REQ - 1;
      res_seen = 0; hold = 0; ena_cnt = 0; clr_due = -1;
    end else begin
      if (clr_due == cyc) chk("det_rst_pulse", det_rst, 1);
      if (det_ena) ena_cnt++;
      if (|(req_valid & req_ready)) begin
        g = 0;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
        chk("ready_onehot", $countones(req_ready), 1);
        chk("grant", g, exp_grant(req_valid, model_last));
        w = req_word[g*WORD_W +: WORD_W];
        q.push_back('{id: g, cnt: ref_hits(w), acc: cyc});
        model_last = g;
        clr_due = cyc + 1;
      end
      if (res_valid) begin
        if (!res_seen) begin
          res_seen = 1;
          chk("result_expected", q.size(), 1);
          if (q.size() > 0) begin
            chk("latency", cyc - q[0].acc, WORD_W + 2);
            chk("shift_len", ena_cnt, WORD_W);
          end
          ena_cnt = 0;
        end
        if (hold) begin
          chk("hold_id", res_id, hold_id);
          chk("hold_count", res_count, hold_cnt);
          chk("no_ready_in_report", req_ready, 0);
        end
        if (res_ready) begin
          if (q.size() > 0) begin
            chk("res_id", res_id, q[0].id);
            chk("res_count", res_count, q[0].cnt);
            void'(q.pop_front());
          end
          res_seen = 0;
          hold = 0;
        end else begin
          hold = 1;
          hold_id = res_id;
          hold_cnt = res_count;
        end
      end
    end
  end

  task automatic offer(input int r, input logic [WORD_W-1:0] w);
    bit got = 0;
    req_word[r*WORD_W +: WORD_W] = w;
    req_valid[r] = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1;
    end
    chk("offer_timeout", got, 1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_res();
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (res_valid) got = 1;
    end
    chk("res_timeout", got, 1);
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (!busy && !res_valid) got = 1;
    end
    chk("idle_timeout", got, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_det"}, {det_rst, det_ena, det_sig}, 0);
    chk({tag, "_res"}, {res_valid, res_id, res_count}, 0);
  endtask

  initial begin
    int prev, n, cnt_ena;
    rst = 1'b1; req_valid = '0; req_word = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    offer(0, 8'b0100_1000);
    wait_res();
    chk("t1_id", res_id, 0);
    chk("t1_count", res_count, 1);
    wait_idle();

    offer(1, 8'hFF);
    wait_res();
    chk("ones_count", res_count, 0);
    wait_idle();
    offer(0, 8'h00);
    wait_res();
    chk("zeros_count", res_count, 0);
    wait_idle();

    req_word = {8'h5A, 8'h96};
    req_valid = 2'b11;
    prev = -1; n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        if (prev >= 0) chk("alternate", req_ready[1], (prev == 0) ? 1 : 0);
        prev = req_ready[1] ? 1 : 0;
        n++;
      end
    end
    chk("four_words", n, 4);
    req_valid = '0;
    wait_idle();

    res_ready = 1'b0;
    req_valid = 2'b11;
    wait_res();
    repeat (5) @(negedge clk);
    chk("held_valid", res_valid, 1);
    @(posedge clk); #1;
    res_ready = 1'b1;
    req_valid = '0;
    wait_idle();

    repeat (800) begin
      @(posedge clk); #1;
      req_valid = NUM_REQ'($urandom);
      req_word  = (NUM_REQ*WORD_W)'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    res_ready = 1'b1;
    wait_idle();

    offer(0, 8'h6D);
    cnt_ena = 0;
    for (int i = 0; i < 30 && cnt_ena < 4; i++) begin
      @(negedge clk);
      if (det_ena) cnt_ena++;
    end
    chk("reach_shift4", cnt_ena, 4);
    #1 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");
    offer(1, 8'hA5);
    wait_res();
    chk("post_rst_id", res_id, 1);
    wait_idle();

`ifdef SEQ_DETECT_SCHEDULER_STATS_EN
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      offer(0, 8'b0100_1000);
      wait_idle();
    end
    chk("total_hits", total_hits, 3);
    chk("words_done", words_done, 3);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("total_hits_rst", total_hits, 0);
    chk("words_done_rst", words_done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
